coarse_time_synch_gen: RTL and testbench
========================================

Name: coarse_time_synch_gen

Overview:
- Parametrised preamble coarse-timing detector for the OFDM receiver front end, sitting between the P/R metric calculator and frequency-offset estimation.
- Detects the frame with a smoothed threshold test P > R>>THR_SH, then finds the end of the correlation plateau using a delayed-difference group/instantaneous maximum search.
- Asserts comp_ena and reports the lock sample index.
- Adds generic widths/depths, a consecutive-hit mode, an explicit FSM, a lock index output and an optional watchdog timeout.

Parameters:
MW, 26, width of P/R metrics (unsigned, format 11.15 at default)
PW, 16, plateau sample width; P_in = P_mag[MW-1:MW-PW]
DLY_B, 9, log2 of delay-line depth (depth DLY = 2^DLY_B = 512)
SMOOTH, 15, threshold hits required to declare frame (1..255)
CONSEC, 0, 0 = hits counted cumulatively; 1 = any miss while ena clears the hit count
THR_SH, 1, right shift applied to R for threshold
FLOOR_B, 8, thr[MW-1:FLOOR_B] must be nonzero (noise floor)
GRP_B, 2, log2 of group length (G = 4 samples)
INS_HOLD, 7, samples without a new instantaneous max before plateau end
IDX_W, 16, lock index / timeout counter width
TIMEOUT_LEN, 4096, ARMED samples before timeout (macro only)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
cyc_i  in  1  frame cycle active; low aborts to IDLE
ena  in  1  sample valid
P_mag  in  MW  |P| metric
R_metric  in  MW  R metric
comp_ena  out  1  lock flag, held until cyc_i low
lock_idx  out  IDX_W  ARMED sample count at lock
timeout  out  1  one-cycle pulse on watchdog expiry
state_o  out  2  FSM state: 0 IDLE, 1 ARMED, 2 LOCKED

Behaviour:
- Reset: state IDLE. All counters, maxima, accumulators and the delay pointer/fill count are 0. comp_ena=0, lock_idx=0, timeout=0.
- cyc_i low, any state: next cycle state IDLE, same clears as reset except lock_idx, which holds its value. Priority: rst > cyc_i low > all else.
- Threshold: thr = R_metric>>THR_SH; hit = (P_mag > thr) & |thr[MW-1:FLOOR_B]. The comparison is unsigned, full MW.
- IDLE:
  - ena=1 & hit: hit_cnt++, saturating at SMOOTH.
  - ena=1 & ~hit: hit_cnt holds if CONSEC=0, clears if CONSEC=1.
  - ena=0: hit_cnt cleared.
  - Registered hit_cnt==SMOOTH → ARMED on the following cycle (1-cycle latency); hit_cnt cleared on entry.
- ARMED (all updates below only on ena=1):
  - Delay line: circular buffer, depth DLY, read-before-write. P_dly is forced to 0 until DLY samples have been written since entry.
  - diff = {0,P_in} − {0,P_dly}, signed PW+1 bits. sidx++ (IDX_W, wraps).
  - Group phase: gcnt counts 0..G-1.
    - At gcnt==0: acc = sext(diff); also grp_new = (grp_max < acc_prev), and grp_max = acc_prev if grp_new.
    - Otherwise: acc += diff.
    - acc and grp_max are signed PW+1+GRP_B bits. grp_max starts at 0 on ARMED entry.
  - Instantaneous: if diff > ins_max then ins_max = diff and ins_cnt = 0; else ins_cnt++ (saturating at INS_HOLD). ins_max starts at 0.
  - Plateau: registered ins_cnt==INS_HOLD & ~grp_new → LOCKED next cycle. Same cycle: comp_ena=1, lock_idx=sidx.
- LOCKED: all datapath frozen; comp_ena held at 1 until cyc_i low.
- ena=0 in ARMED: no state advance, nothing updates.
- Delay contents are never cleared; the fill counter guarantees deterministic output.

Optional Feature:
- Macro: CTS_TIMEOUT_EN.
- With the macro defined: in ARMED, when sidx reaches TIMEOUT_LEN without a plateau, timeout pulses 1 cycle and state returns to IDLE with all ARMED registers cleared. comp_ena stays 0. Plateau and timeout in the same cycle: plateau wins.
- Without the macro: timeout tied 0, no watchdog logic, and ARMED persists until plateau or cyc_i low.

Test Plan:
- Reset/default: rst 3 cycles, cyc_i=1, P=0, R=0 → state_o=0, comp_ena=0, lock_idx=0, timeout=0 throughout 100 cycles.
- Noise floor: P=1000, R=200 (thr=100 < 2^8) for 50 ena cycles → stays IDLE. Then R=4096, P=4000 (thr=2048) → ARMED exactly 16 cycles after first hit.
- CONSEC=1: 14 hits, 1 miss, 15 hits → ARMED only after the second run. With CONSEC=0 the same stimulus → ARMED after the 15th cumulative hit.
- Plateau: ARMED with P_in ramp 0→1023 over 1024 samples, then constant 1023 → comp_ena rises; lock_idx equals sidx at the INS_HOLD-th sample after the last diff increase, per the golden model.
- Abort: cyc_i low for 1 cycle while LOCKED → comp_ena=0 and state_o=0 next cycle; lock_idx retained. Re-detection works without rst.
- CTS_TIMEOUT_EN, TIMEOUT_LEN=64: ARMED with diff strictly increasing → timeout=1 for exactly one cycle at sample 64, state_o=0, comp_ena=0.

Source files
------------

// File: rtl/coarse_time_synch_gen.sv
// Preamble coarse-timing detector: smoothed threshold detection followed by a plateau-end search.
// Define CTS_TIMEOUT_EN to add a watchdog that returns ARMED to IDLE after TIMEOUT_LEN samples.
module coarse_time_synch_gen #(
  parameter int MW       = 26,
  parameter int PW       = 16,
  parameter int DLY_B    = 9,
  parameter int SMOOTH   = 15,
  parameter int CONSEC   = 0,
  parameter int THR_SH   = 1,
  parameter int FLOOR_B  = 8,
  parameter int GRP_B    = 2,
  parameter int INS_HOLD = 7,
  parameter int IDX_W    = 16
`ifdef CTS_TIMEOUT_EN
  , parameter int TIMEOUT_LEN = 4096
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cyc_i,
  input  logic             ena,
  input  logic [MW-1:0]    P_mag,
  input  logic [MW-1:0]    R_metric,
  output logic             comp_ena,
  output logic [IDX_W-1:0] lock_idx,
  output logic             timeout,
  output logic [1:0]       state_o
);

  localparam int DLY = 1 << DLY_B;
  localparam int AW  = PW + 1 + GRP_B;
  localparam int HW  = $clog2(SMOOTH + 1);
  localparam int IW  = $clog2(INS_HOLD + 1);
  localparam logic [DLY_B:0] DLY_FULL = (DLY_B + 1)'(DLY);
  localparam logic [HW-1:0]  SMOOTH_C = HW'(SMOOTH);
  localparam logic [IW-1:0]  HOLD_C   = IW'(INS_HOLD);
`ifdef CTS_TIMEOUT_EN
  localparam logic [IDX_W-1:0] TMO_C = IDX_W'(TIMEOUT_LEN);
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, LOCKED = 2'd2} state_t;

  state_t state, state_nx;

  logic [MW-1:0]        thr;
  logic                 hit;
  logic [PW-1:0]        p_in;
  logic [PW-1:0]        p_dly;
  logic [PW-1:0]        dly_mem [DLY];
  logic [DLY_B-1:0]     wr_ptr;
  logic [DLY_B:0]       fill_cnt;
  logic signed [PW:0]   diff;
  logic signed [AW-1:0] diff_ext;
  logic [HW-1:0]        hit_cnt;
  logic [IDX_W-1:0]     sidx;
  logic [GRP_B-1:0]     gcnt;
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] grp_max;
  logic                 grp_new;
  logic signed [PW:0]   ins_max;
  logic [IW-1:0]        ins_cnt;
  logic                 arm_step;
  logic                 do_lock;
  logic                 do_tmo;
  logic                 arm_clr;

  assign thr      = R_metric >> THR_SH;
  assign hit      = (P_mag > thr) && (|thr[MW-1:FLOOR_B]);
  assign p_in     = P_mag[MW-1:MW-PW];
  // Until the line has wrapped once its contents are stale, so the delayed tap reads as zero.
  assign p_dly    = (fill_cnt == DLY_FULL) ? dly_mem[wr_ptr] : '0;
  assign diff     = $signed({1'b0, p_in}) - $signed({1'b0, p_dly});
  assign diff_ext = {{GRP_B{diff[PW]}}, diff};
  assign state_o  = state;
  assign arm_clr  = rst | ~cyc_i | do_tmo;

  always_comb begin
    state_nx = state;
    arm_step = 1'b0;
    do_lock  = 1'b0;
    do_tmo   = 1'b0;
    case (state)
      IDLE:   if (hit_cnt == SMOOTH_C) state_nx = ARMED;
      ARMED: begin
        if (ena) begin
          arm_step = 1'b1;
          if (ins_cnt == HOLD_C && !grp_new) begin
            do_lock  = 1'b1;
            state_nx = LOCKED;
          end
`ifdef CTS_TIMEOUT_EN
          else if (sidx == TMO_C) begin
            do_tmo   = 1'b1;
            state_nx = IDLE;
          end
`endif
        end
      end
      LOCKED: state_nx = LOCKED;
      default: state_nx = IDLE;
    endcase
    if (!cyc_i) state_nx = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= '0;
      comp_ena <= 1'b0;
      lock_idx <= '0;
      timeout  <= 1'b0;
    end else if (!cyc_i) begin
      hit_cnt  <= '0;
      comp_ena <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      timeout <= do_tmo;
      if (state != IDLE || hit_cnt == SMOOTH_C) hit_cnt <= '0;
      else if (!ena)                            hit_cnt <= '0;
      else if (hit)                             hit_cnt <= hit_cnt + 1'b1;
      else if (CONSEC != 0)                     hit_cnt <= '0;
      if (do_lock) begin
        comp_ena <= 1'b1;
        lock_idx <= sidx;
      end
    end
  end

  // The delay memory is deliberately never cleared; fill_cnt masks its stale contents.
  always_ff @(posedge clk) begin
    if (arm_step && !arm_clr) dly_mem[wr_ptr] <= p_in;
  end

  always_ff @(posedge clk) begin
    if (arm_clr) begin
      wr_ptr   <= '0;
      fill_cnt <= '0;
      sidx     <= '0;
      gcnt     <= '0;
      acc      <= '0;
      grp_max  <= '0;
      grp_new  <= 1'b0;
      ins_max  <= '0;
      ins_cnt  <= '0;
    end else if (arm_step) begin
      wr_ptr <= wr_ptr + 1'b1;
      if (fill_cnt != DLY_FULL) fill_cnt <= fill_cnt + 1'b1;
      sidx <= sidx + 1'b1;
      gcnt <= gcnt + 1'b1;
      if (gcnt == '0) begin
        acc     <= diff_ext;
        grp_new <= (grp_max < acc);
        if (grp_max < acc) grp_max <= acc;
      end else begin
        acc <= acc + diff_ext;
      end
      if (diff > ins_max) begin
        ins_max <= diff;
        ins_cnt <= '0;
      end else if (ins_cnt != HOLD_C) begin
        ins_cnt <= ins_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_coarse_time_synch_gen.sv
// Directed bench for coarse_time_synch_gen: one cumulative-hit and one consecutive-hit instance share stimulus.
// With CTS_TIMEOUT_EN defined the watchdog is exercised at TIMEOUT_LEN=64.
module tb_coarse_time_synch_gen;

  logic        clk = 1'b0;
  logic        rst, cyc_i, ena;
  logic [25:0] p_mag, r_metric;
  logic        comp_ena, timeout, comp_ena_c, timeout_c;
  logic [15:0] lock_idx, lock_idx_c;
  logic [1:0]  state_o, state_o_c;

  int total = 0;
  int bad   = 0;

  coarse_time_synch_gen #(
    .CONSEC(0)
`ifdef CTS_TIMEOUT_EN
    , .TIMEOUT_LEN(64)
`endif
  ) dut (
    .clk(clk), .rst(rst), .cyc_i(cyc_i), .ena(ena), .P_mag(p_mag), .R_metric(r_metric),
    .comp_ena(comp_ena), .lock_idx(lock_idx), .timeout(timeout), .state_o(state_o)
  );

  coarse_time_synch_gen #(
    .CONSEC(1)
`ifdef CTS_TIMEOUT_EN
    , .TIMEOUT_LEN(64)
`endif
  ) dut_c (
    .clk(clk), .rst(rst), .cyc_i(cyc_i), .ena(ena), .P_mag(p_mag), .R_metric(r_metric),
    .comp_ena(comp_ena_c), .lock_idx(lock_idx_c), .timeout(timeout_c), .state_o(state_o_c)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs and return #1 after the capturing edge.
  task automatic applyStimulus(input logic e, input logic [25:0] p, input logic [25:0] r);
    ena      = e;
    p_mag    = p;
    r_metric = r;
    @(posedge clk);
    #1;
  endtask

  task automatic abortCycle();
    cyc_i = 1'b0;
    applyStimulus(1'b0, 26'd0, 26'd0);
    cyc_i = 1'b1;
  endtask

  task automatic detectFrame(input string tag);
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1'b1, 26'd4000, 26'd4096);
      checkOutput(tag, 32'(state_o), (i == 16) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] bench hung");
  end

  initial begin
    int lock_n;
    logic [25:0] pv;
    rst = 1'b1; cyc_i = 1'b1; ena = 1'b0; p_mag = '0; r_metric = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_state", 32'(state_o), 32'd0);
    checkOutput("rst_lidx", 32'(lock_idx), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 100; i++) begin
      applyStimulus(1'b1, 26'd0, 26'd0);
      checkOutput("idle_state", 32'(state_o), 32'd0);
      checkOutput("idle_comp", 32'(comp_ena), 32'd0);
      checkOutput("idle_lidx", 32'(lock_idx), 32'd0);
      checkOutput("idle_tmo", 32'(timeout), 32'd0);
    end

    for (int i = 0; i < 50; i++) begin
      applyStimulus(1'b1, 26'd1000, 26'd200);
      checkOutput("floor_state", 32'(state_o), 32'd0);
    end

    detectFrame("arm_latency");
    checkOutput("arm_c_state", 32'(state_o_c), 32'd1);

    // Ramp 0..1023 on P_in; the plateau end is expected at sample 521 with ena bubbles that must not count.
    lock_n = -1;
    for (int n = 0; n < 700 && lock_n < 0; n++) begin
      if (n % 97 == 50) begin
        applyStimulus(1'b0, 26'($urandom), 26'($urandom));
        checkOutput("bubble_state", 32'(state_o), 32'd1);
      end
      pv = 26'((n > 1023) ? 1023 : n) << 10;
      applyStimulus(1'b1, pv, 26'd0);
      if (comp_ena) lock_n = n;
    end
    checkOutput("lock_sample", 32'(lock_n), 32'd521);
    checkOutput("lock_idx", 32'(lock_idx), 32'd521);
    checkOutput("lock_state", 32'(state_o), 32'd2);
    checkOutput("lock_idx_c", 32'(lock_idx_c), 32'd521);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 26'($urandom), 26'($urandom));
      checkOutput("hold_comp", 32'(comp_ena), 32'd1);
      checkOutput("hold_lidx", 32'(lock_idx), 32'd521);
      checkOutput("hold_state", 32'(state_o), 32'd2);
    end

    abortCycle();
    checkOutput("abort_state", 32'(state_o), 32'd0);
    checkOutput("abort_comp", 32'(comp_ena), 32'd0);
    checkOutput("abort_lidx", 32'(lock_idx), 32'd521);

    detectFrame("redetect");
    checkOutput("redetect_comp", 32'(comp_ena), 32'd0);
    checkOutput("redetect_lidx", 32'(lock_idx), 32'd521);

    // 14 hits, one miss, then hits: cumulative arms at edge 17, consecutive at edge 31.
    abortCycle();
    for (int e = 1; e <= 31; e++) begin
      applyStimulus(1'b1, (e == 15) ? 26'd0 : 26'd4000, 26'd4096);
      if (e <= 17) checkOutput("cum_state", 32'(state_o), (e == 17) ? 32'd1 : 32'd0);
      checkOutput("consec_state", 32'(state_o_c), (e == 31) ? 32'd1 : 32'd0);
    end

`ifdef CTS_TIMEOUT_EN
    abortCycle();
    detectFrame("tmo_arm");
    for (int n = 0; n <= 64; n++) begin
      applyStimulus(1'b1, 26'(n) << 10, 26'd0);
      checkOutput("tmo_pulse", 32'(timeout), (n == 64) ? 32'd1 : 32'd0);
    end
    checkOutput("tmo_state", 32'(state_o), 32'd0);
    checkOutput("tmo_comp", 32'(comp_ena), 32'd0);
    applyStimulus(1'b0, 26'd0, 26'd0);
    checkOutput("tmo_one_cycle", 32'(timeout), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
